// File: rtl/pattern_stream_counter.sv
// pattern_stream_counter: scans a TERM-delimited symbol stream read from
// a synchronous-read memory and counts matches of programmable patterns.
//
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   start          : one-cycle pulse that begins a scan (ignored while busy)
//   overlap_en     : 1 = overlapping matches counted, 0 = non-overlapping
//   pattern        : symbol j of pattern i at [(i*MAX_LEN+j)*SYM_W +: SYM_W]
//   pattern_mask   : bit i*MAX_LEN+j makes symbol j of pattern i a wildcard
//   pattern_len    : per-pattern length; 0 or > MAX_LEN disables it
//   mem_en/addr    : memory read request; mem_data returns MEM_LAT later
//   busy/done      : scan in progress / scan complete (held)
//   overflow       : scan hit the top address without a double terminator
//   count_sel/out  : selects one saturating counter for display
//   symbol_count   : non-terminator symbols consumed
module pattern_stream_counter #(
   parameter int NUM_PATTERNS = 5,
   parameter int MAX_LEN      = 4,
   parameter int SYM_W        = 4,
   parameter int COUNT_W      = 8,
   parameter int ADDR_W       = 8,
   parameter int MEM_LAT      = 1,
   parameter logic [SYM_W-1:0] TERM = SYM_W'(4'hF),
   localparam int LEN_W = $clog2(MAX_LEN + 1),
   localparam int SEL_W = $clog2(NUM_PATTERNS),
   localparam int NSYM  = NUM_PATTERNS * MAX_LEN
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          overlap_en,
   input  logic [NSYM*SYM_W-1:0]         pattern,
   input  logic [NSYM-1:0]               pattern_mask,
   input  logic [NUM_PATTERNS*LEN_W-1:0] pattern_len,
   output logic                          mem_en,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic [SYM_W-1:0]              mem_data,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow,
   input  logic [SEL_W-1:0]              count_sel,
   output logic [COUNT_W-1:0]            count_out,
   output logic [ADDR_W:0]               symbol_count
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   state_t state_q, state_n;

   logic [MEM_LAT-1:0] tag_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [SYM_W-1:0]   pat_q [NSYM];
   logic [NSYM-1:0]    msk_q;
   logic [LEN_W-1:0]   len_q [NUM_PATTERNS];
   logic               ovl_q;
   logic [SYM_W-1:0]   win_q [MAX_LEN];
   logic [SYM_W-1:0]   win_n [MAX_LEN];
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_n;
   logic [LEN_W-1:0]   cool_q [NUM_PATTERNS];
   logic [COUNT_W-1:0] cnt_q [NUM_PATTERNS];
   logic [ADDR_W:0]    sym_cnt_q;
   logic               prev_term_q;
   logic               ovf_q;

   logic go;
   logic consume;
   logic is_term;
   logic sym_take;
   logic sep;
   logic eos;
   logic drained;
   logic [NUM_PATTERNS-1:0] hit;

   assign go       = start && (state_q == IDLE || state_q == DONE);
   assign consume  = tag_q[MEM_LAT-1] &&
                     (state_q == SCAN || state_q == DRAIN);
   assign is_term  = (mem_data == TERM);
   assign sym_take = consume && !is_term;
   assign sep      = consume && is_term && !prev_term_q;
   assign eos      = consume && is_term && prev_term_q;
   assign drained  = (state_q == DRAIN) && (tag_q == '0);

   // Window as it will look once the incoming symbol is shifted in, so
   // matches are judged on the symbol being consumed this cycle.
   always_comb begin
      win_n[0] = mem_data;
      for (int k = 1; k < MAX_LEN; k++) begin
         win_n[k] = win_q[k-1];
      end
      if (int'(fill_q) >= MAX_LEN) begin
         fill_n = fill_q;
      end else begin
         fill_n = fill_q + LEN_W'(1);
      end
   end

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_PATTERNS; i++) begin
         int l;
         l = int'(len_q[i]);
         if (l != 0 && l <= MAX_LEN) begin
            hit[i] = (fill_n >= len_q[i]) &&
                     (ovl_q || cool_q[i] == '0);
            for (int j = 0; j < MAX_LEN; j++) begin
               if (j < l &&
                   !msk_q[i*MAX_LEN+j] &&
                   pat_q[i*MAX_LEN+j] != win_n[l-1-j]) begin
                  hit[i] = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) state_n = SCAN;
         end
         SCAN: begin
            if (eos) begin
               state_n = DONE;
            end else if (&addr_q) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (eos || drained) state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      mem_en = (state_q == SCAN);
      busy   = (state_q == SCAN) || (state_q == DRAIN);
      done   = (state_q == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tag_q       <= '0;
         addr_q      <= '0;
         msk_q       <= '0;
         ovl_q       <= 1'b0;
         fill_q      <= '0;
         sym_cnt_q   <= '0;
         prev_term_q <= 1'b0;
         ovf_q       <= 1'b0;
         for (int k = 0; k < NSYM; k++) pat_q[k] <= '0;
         for (int k = 0; k < MAX_LEN; k++) win_q[k] <= '0;
         for (int i = 0; i < NUM_PATTERNS; i++) begin
            len_q[i]  <= '0;
            cool_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else if (go) begin
         // Reads still in flight from a previous scan must not leak in.
         tag_q       <= '0;
         addr_q      <= '0;
         msk_q       <= pattern_mask;
         ovl_q       <= overlap_en;
         fill_q      <= '0;
         sym_cnt_q   <= '0;
         prev_term_q <= 1'b0;
         ovf_q       <= 1'b0;
         for (int k = 0; k < NSYM; k++) begin
            pat_q[k] <= pattern[k*SYM_W +: SYM_W];
         end
         for (int k = 0; k < MAX_LEN; k++) win_q[k] <= '0;
         for (int i = 0; i < NUM_PATTERNS; i++) begin
            len_q[i]  <= pattern_len[i*LEN_W +: LEN_W];
            cool_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         tag_q[0] <= mem_en;
         for (int k = 1; k < MEM_LAT; k++) tag_q[k] <= tag_q[k-1];
         if (mem_en) addr_q <= addr_q + ADDR_W'(1);
         if (consume) prev_term_q <= is_term;
         if (sym_take) begin
            for (int k = 0; k < MAX_LEN; k++) win_q[k] <= win_n[k];
            fill_q    <= fill_n;
            sym_cnt_q <= sym_cnt_q + (ADDR_W+1)'(1);
            for (int i = 0; i < NUM_PATTERNS; i++) begin
               if (hit[i] && cnt_q[i] != '1) begin
                  cnt_q[i] <= cnt_q[i] + COUNT_W'(1);
               end
               // Cooldown of L-1 forces the next match to start
               // after the end of this one.
               if (hit[i] && !ovl_q) begin
                  cool_q[i] <= len_q[i] - LEN_W'(1);
               end else if (cool_q[i] != '0) begin
                  cool_q[i] <= cool_q[i] - LEN_W'(1);
               end
            end
         end
         if (sep) begin
            fill_q <= '0;
            for (int i = 0; i < NUM_PATTERNS; i++) cool_q[i] <= '0;
         end
         if (drained) ovf_q <= 1'b1;
      end
   end

   always_comb begin
      count_out = '0;
      if (int'(count_sel) < NUM_PATTERNS) begin
         count_out = cnt_q[count_sel];
      end
   end

   assign mem_addr     = addr_q;
   assign overflow     = ovf_q;
   assign symbol_count = sym_cnt_q;

endmodule

// File: tb/tb_pattern_stream_counter.sv
// tb_pattern_stream_counter: drives three DUT variants (default, narrow
// counters, 3-cycle memory latency) against a stream-level reference.
module tb_pattern_stream_counter;

   localparam int NP  = 5;
   localparam int ML  = 4;
   localparam int LW  = 3;
   localparam int SLW = 3;

   logic clock = 1'b0;
   logic reset;
   logic start;
   logic overlap_en;
   logic [NP*ML*4-1:0] pattern;
   logic [NP*ML-1:0]   pattern_mask;
   logic [NP*LW-1:0]   pattern_len;
   logic [SLW-1:0]     count_sel;

   logic       mem_en_a, mem_en_b, mem_en_c;
   logic [7:0] mem_addr_a, mem_addr_b, mem_addr_c;
   logic [3:0] mem_data_a, mem_data_b, mem_data_c;
   logic [3:0] lat_c [3];
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;
   logic       ovf_a, ovf_b, ovf_c;
   logic [7:0] cnt_a, cnt_c;
   logic [2:0] cnt_b;
   logic [8:0] sym_a, sym_b, sym_c;

   logic [3:0] mem [256];
   int  seq [$];
   int  seg [$];
   int  m_sym [NP][ML];
   bit  m_msk [NP][ML];
   int  m_len [NP];
   bit  m_ovl;
   int  exp_cnt [NP];
   int  exp_sym;
   bit  exp_ovf;
   int  n_cmp = 0;
   int  n_bad = 0;

   always #5 clock = ~clock;

   pattern_stream_counter u_a (
      .clock(clock), .reset(reset), .start(start),
      .overlap_en(overlap_en), .pattern(pattern),
      .pattern_mask(pattern_mask), .pattern_len(pattern_len),
      .mem_en(mem_en_a), .mem_addr(mem_addr_a),
      .mem_data(mem_data_a), .busy(busy_a), .done(done_a),
      .overflow(ovf_a), .count_sel(count_sel),
      .count_out(cnt_a), .symbol_count(sym_a)
   );

   pattern_stream_counter #(.COUNT_W(3)) u_b (
      .clock(clock), .reset(reset), .start(start),
      .overlap_en(overlap_en), .pattern(pattern),
      .pattern_mask(pattern_mask), .pattern_len(pattern_len),
      .mem_en(mem_en_b), .mem_addr(mem_addr_b),
      .mem_data(mem_data_b), .busy(busy_b), .done(done_b),
      .overflow(ovf_b), .count_sel(count_sel),
      .count_out(cnt_b), .symbol_count(sym_b)
   );

   pattern_stream_counter #(.MEM_LAT(3)) u_c (
      .clock(clock), .reset(reset), .start(start),
      .overlap_en(overlap_en), .pattern(pattern),
      .pattern_mask(pattern_mask), .pattern_len(pattern_len),
      .mem_en(mem_en_c), .mem_addr(mem_addr_c),
      .mem_data(mem_data_c), .busy(busy_c), .done(done_c),
      .overflow(ovf_c), .count_sel(count_sel),
      .count_out(cnt_c), .symbol_count(sym_c)
   );

   always @(posedge clock) begin
      mem_data_a <= mem[mem_addr_a];
      mem_data_b <= mem[mem_addr_b];
      lat_c[0]   <= mem[mem_addr_c];
      lat_c[1]   <= lat_c[0];
      lat_c[2]   <= lat_c[1];
   end
   assign mem_data_c = lat_c[2];

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic clr_pat();
      for (int i = 0; i < NP; i++) begin
         m_len[i] = 0;
         for (int j = 0; j < ML; j++) begin
            m_sym[i][j] = 0;
            m_msk[i][j] = 1'b0;
         end
      end
      m_ovl = 1'b1;
   endtask

   task automatic pack();
      for (int i = 0; i < NP; i++) begin
         for (int j = 0; j < ML; j++) begin
            pattern[(i*ML+j)*4 +: 4] = 4'(m_sym[i][j]);
            pattern_mask[i*ML+j]     = m_msk[i][j];
         end
         pattern_len[i*LW +: LW] = 3'(m_len[i]);
      end
      overlap_en = m_ovl;
   endtask

   task automatic load_seq();
      for (int a = 0; a < 256; a++) begin
         mem[a] = (a < seq.size()) ? 4'(seq[a]) : 4'h0;
      end
   endtask

   // Greedy leftmost search within one separator-free segment.
   task automatic count_seg();
      for (int i = 0; i < NP; i++) begin
         int l;
         int p;
         bit ok;
         l = m_len[i];
         if (l >= 1 && l <= ML) begin
            p = 0;
            while (p + l <= seg.size()) begin
               ok = 1'b1;
               for (int j = 0; j < l; j++) begin
                  if (!m_msk[i][j] && seg[p+j] != m_sym[i][j]) ok = 1'b0;
               end
               if (ok) begin
                  exp_cnt[i]++;
                  p += m_ovl ? 1 : l;
               end else begin
                  p++;
               end
            end
         end
      end
      seg.delete();
   endtask

   task automatic model();
      bit prevf;
      bit fin;
      prevf   = 1'b0;
      fin     = 1'b0;
      exp_sym = 0;
      exp_ovf = 1'b1;
      seg.delete();
      for (int i = 0; i < NP; i++) exp_cnt[i] = 0;
      for (int a = 0; a < 256; a++) begin
         if (!fin) begin
            if (mem[a] == 4'hF) begin
               if (prevf) begin
                  fin     = 1'b1;
                  exp_ovf = 1'b0;
               end
               count_seg();
               prevf = 1'b1;
            end else begin
               seg.push_back(int'(mem[a]));
               exp_sym++;
               prevf = 1'b0;
            end
         end
      end
      count_seg();
   endtask

   task automatic run_scan(input bit disturb, input string nm);
      int cyc;
      model();
      pack();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      if (disturb) begin
         pattern      = (NP*ML*4)'({$urandom, $urandom, $urandom});
         pattern_mask = (NP*ML)'($urandom);
         pattern_len  = (NP*LW)'($urandom);
         overlap_en   = ~overlap_en;
         repeat (2) @(negedge clock);
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      cyc = 0;
      while (!(done_a && done_b && done_c) && cyc < 800) begin
         @(negedge clock);
         cyc++;
      end
      chk($sformatf("%s done_a", nm), done_a, 1);
      chk($sformatf("%s done_b", nm), done_b, 1);
      chk($sformatf("%s done_c", nm), done_c, 1);
      chk($sformatf("%s busy_a", nm), busy_a, 0);
      chk($sformatf("%s mem_en_c", nm), mem_en_c, 0);
      chk($sformatf("%s ovf_a", nm), ovf_a, exp_ovf);
      chk($sformatf("%s ovf_b", nm), ovf_b, exp_ovf);
      chk($sformatf("%s ovf_c", nm), ovf_c, exp_ovf);
      chk($sformatf("%s sym_a", nm), sym_a, exp_sym);
      chk($sformatf("%s sym_b", nm), sym_b, exp_sym);
      chk($sformatf("%s sym_c", nm), sym_c, exp_sym);
      for (int s = 0; s < 8; s++) begin
         int ea;
         int eb;
         count_sel = 3'(s);
         #1;
         ea = (s < NP) ? sat(exp_cnt[s], 255) : 0;
         eb = (s < NP) ? sat(exp_cnt[s], 7) : 0;
         chk($sformatf("%s cnt_a[%0d]", nm, s), cnt_a, ea);
         chk($sformatf("%s cnt_b[%0d]", nm, s), cnt_b, eb);
         chk($sformatf("%s cnt_c[%0d]", nm, s), cnt_c, ea);
      end
      count_sel = '0;
   endtask

   task automatic gen_mem(input bit with_end);
      bit pf;
      int r;
      int p;
      logic [3:0] s;
      pf = 1'b0;
      for (int a = 0; a < 256; a++) begin
         r = $urandom_range(0, 9);
         s = (r < 7) ? 4'(r % 4) : 4'hF;
         if (pf && s == 4'hF) s = 4'(r % 4);
         mem[a] = s;
         pf = (s == 4'hF);
      end
      if (with_end) begin
         p = $urandom_range(20, 255);
         mem[p-1] = 4'hF;
         mem[p]   = 4'hF;
      end
   endtask

   task automatic gen_pat();
      for (int i = 0; i < NP; i++) begin
         m_len[i] = $urandom_range(0, 6);
         for (int j = 0; j < ML; j++) begin
            m_sym[i][j] = $urandom_range(0, 3);
            m_msk[i][j] = ($urandom_range(0, 4) == 0);
         end
      end
      m_ovl = $urandom_range(0, 1);
   endtask

   task automatic get_cnt(input int s, output int a, output int b);
      count_sel = 3'(s);
      #1;
      a = int'(cnt_a);
      b = int'(cnt_b);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int ca;
      int cb;
      reset        = 1'b1;
      start        = 1'b0;
      overlap_en   = 1'b0;
      pattern      = '0;
      pattern_mask = '0;
      pattern_len  = '0;
      count_sel    = '0;
      for (int a = 0; a < 256; a++) mem[a] = 4'h0;
      repeat (3) @(negedge clock);
      chk("rst busy", busy_a, 0);
      chk("rst done", done_a, 0);
      chk("rst ovf", ovf_a, 0);
      chk("rst mem_en", mem_en_a, 0);
      chk("rst mem_addr", mem_addr_a, 0);
      chk("rst cnt", cnt_a, 0);
      chk("rst sym", sym_a, 0);
      reset = 1'b0;
      @(negedge clock);

      clr_pat();
      m_sym[0][0] = 1; m_sym[0][1] = 2; m_sym[0][2] = 3;
      m_len[0] = 3;
      seq = '{1, 2, 3, 1, 2, 3, 15, 15};
      load_seq();
      run_scan(1'b0, "t1");
      get_cnt(0, ca, cb);
      chk("t1 const cnt", ca, 2);
      chk("t1 const sym", sym_c, 6);

      clr_pat();
      m_sym[0][0] = 1; m_sym[0][1] = 1;
      m_len[0] = 2;
      seq = '{1, 1, 1, 1, 15, 15};
      load_seq();
      m_ovl = 1'b1;
      run_scan(1'b0, "t2ov");
      get_cnt(0, ca, cb);
      chk("t2 const ovl", ca, 3);
      m_ovl = 1'b0;
      run_scan(1'b0, "t2no");
      get_cnt(0, ca, cb);
      chk("t2 const novl", ca, 2);

      clr_pat();
      m_sym[1][0] = 2; m_sym[1][1] = 7; m_sym[1][2] = 2;
      m_msk[1][1] = 1'b1;
      m_len[1] = 3;
      seq = '{2, 5, 2, 2, 9, 2, 15, 15};
      load_seq();
      run_scan(1'b0, "t3");
      get_cnt(1, ca, cb);
      chk("t3 const wild", ca, 2);

      clr_pat();
      m_sym[0][0] = 2; m_sym[0][1] = 3; m_len[0] = 2;
      m_sym[1][0] = 3; m_sym[1][1] = 4; m_len[1] = 2;
      seq = '{1, 2, 15, 3, 4, 15, 15};
      load_seq();
      run_scan(1'b0, "t4");
      get_cnt(0, ca, cb);
      chk("t4 const cross", ca, 0);
      get_cnt(1, ca, cb);
      chk("t4 const seg", ca, 1);

      clr_pat();
      m_sym[0][0] = 7; m_len[0] = 1;
      seq.delete();
      for (int k = 0; k < 10; k++) seq.push_back(7);
      seq.push_back(15);
      seq.push_back(15);
      load_seq();
      run_scan(1'b0, "t5");
      get_cnt(0, ca, cb);
      chk("t5 const wide", ca, 10);
      chk("t5 const sat", cb, 7);

      gen_mem(1'b0);
      gen_pat();
      run_scan(1'b0, "t6ovf");
      chk("t6 const ovf", ovf_a, 1);

      clr_pat();
      m_sym[0][0] = 1; m_len[0] = 1;
      for (int a = 0; a < 256; a++) mem[a] = 4'h1;
      pack();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      chk("t7 pre busy", busy_a, 1);
      chk("t7 pre cnt nz", (cnt_a != 0), 1);
      reset = 1'b1;
      @(negedge clock);
      chk("t7 busy_a", busy_a, 0);
      chk("t7 busy_c", busy_c, 0);
      chk("t7 done_a", done_a, 0);
      chk("t7 cnt_a", cnt_a, 0);
      chk("t7 cnt_b", cnt_b, 0);
      chk("t7 sym_a", sym_a, 0);
      reset = 1'b0;
      clr_pat();
      m_sym[0][0] = 1; m_sym[0][1] = 2; m_sym[0][2] = 3;
      m_len[0] = 3;
      seq = '{1, 2, 3, 1, 2, 3, 15, 15};
      load_seq();
      run_scan(1'b0, "t7re");

      for (int t = 0; t < 24; t++) begin
         gen_mem(t % 3 != 0);
         gen_pat();
         run_scan(t % 2 == 1, $sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
